fp_special_case_pipe: RTL

FP_SPECIAL_CASE_PIPE -- requirements
Module: fp_special_case_pipe

---
 rtl/fp_special_case_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fp_special_case_pipe.sv
// Two-stage classifier/resolver for IEEE-style add/sub/mul special cases.
// Optional macro FPSC_DAZ_EN treats subnormal operands as signed zeros.
module fp_special_case_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       is_special,
    output logic                       invalid,
    output logic                       flag_invalid,
    input  logic                       clr_flags
);

    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic         sgn;
        logic         zero;
        logic         inf;
        logic         nan;
        logic         snan;
        logic [W-1:0] val;
    } cls_t;

    // flip applies the subtraction sign inversion to b
    function automatic cls_t classify(input logic [W-1:0] x,
                                      input logic flip);
        cls_t             c;
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        s      = x[W-1] ^ flip;
        e      = x[W-2 -: EXP_W];
        m      = x[MAN_W-1:0];
        c.sgn  = s;
        c.nan  = (&e) && (|m);
        c.inf  = (&e) && !(|m);
        c.snan = (&e) && (|m) && !m[MAN_W-1];
`ifdef FPSC_DAZ_EN
        c.zero = !(|e);
        c.val  = c.zero ? {s, {(W-1){1'b0}}} : {s, e, m};
`else
        c.zero = !(|e) && !(|m);
        c.val  = {s, e, m};
`endif
        return c;
    endfunction

    logic         s1_valid_q;
    logic         s1_mul_q;
    cls_t         ca_q;
    cls_t         cb_q;
    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic         is_special_q;
    logic         invalid_q;
    logic         flag_q;

    logic         stall;
    logic         advance;
    logic [W-1:0] result_d;
    logic         is_special_d;
    logic         invalid_d;
    logic         psign;
    logic         flag_d;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;
    assign psign    = ca_q.sgn ^ cb_q.sgn;

    always_comb begin
        result_d     = '0;
        is_special_d = 1'b0;
        invalid_d    = 1'b0;
        if (s1_valid_q) begin
            if (ca_q.nan || cb_q.nan) begin
                result_d     = QNAN;
                is_special_d = 1'b1;
                invalid_d    = ca_q.snan || cb_q.snan;
            end else if (s1_mul_q) begin
                if ((ca_q.inf && cb_q.zero) || (cb_q.inf && ca_q.zero)) begin
                    result_d     = QNAN;
                    is_special_d = 1'b1;
                    invalid_d    = 1'b1;
                end else if (ca_q.inf || cb_q.inf) begin
                    result_d     = {psign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    is_special_d = 1'b1;
                end else if (ca_q.zero || cb_q.zero) begin
                    result_d     = {psign, {(W-1){1'b0}}};
                    is_special_d = 1'b1;
                end
            end else begin
                if (ca_q.inf && cb_q.inf && (ca_q.sgn != cb_q.sgn)) begin
                    result_d     = QNAN;
                    is_special_d = 1'b1;
                    invalid_d    = 1'b1;
                end else if (ca_q.inf) begin
                    result_d     = ca_q.val;
                    is_special_d = 1'b1;
                end else if (cb_q.inf) begin
                    result_d     = cb_q.val;
                    is_special_d = 1'b1;
                end else if (ca_q.zero && cb_q.zero) begin
                    result_d     = {ca_q.sgn & cb_q.sgn, {(W-1){1'b0}}};
                    is_special_d = 1'b1;
                end else if (ca_q.zero) begin
                    result_d     = cb_q.val;
                    is_special_d = 1'b1;
                end else if (cb_q.zero) begin
                    result_d     = ca_q.val;
                    is_special_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_mul_q     <= 1'b0;
            ca_q         <= '0;
            cb_q         <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            is_special_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else if (advance) begin
            s1_valid_q   <= in_valid;
            s1_mul_q     <= (op == 2'b10);
            ca_q         <= classify(a, 1'b0);
            cb_q         <= classify(b, op == 2'b01);
            out_valid_q  <= s1_valid_q;
            result_q     <= result_d;
            is_special_q <= is_special_d;
            invalid_q    <= invalid_d;
        end
    end

    // a new invalid transfer wins over a same-cycle clear
    always_comb begin
        flag_d = flag_q;
        if (clr_flags)
            flag_d = 1'b0;
        if (out_valid_q && out_ready && invalid_q)
            flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            flag_q <= 1'b0;
        else
            flag_q <= flag_d;
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign is_special   = is_special_q;
    assign invalid      = invalid_q;
    assign flag_invalid = flag_q;

endmodule
